// File: rtl/lcd_cmd_sched.sv
// Two-requester round-robin command scheduler in front of the LCD image controller.
// Optional watchdog on the wait states is enabled with `define LCD_SCHED_TIMEOUT_EN.
module lcd_cmd_sched #(
    parameter int          DEPTH     = 4,
    parameter logic [2:0]  WRITE_CMD = 3'd0,
    parameter int          TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [2:0]  req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_cmd,
    output logic        req1_ready,
    output logic [2:0]  lcd_cmd,
    output logic        lcd_cmd_valid,
    input  logic        lcd_busy,
    input  logic        lcd_done,
    output logic        frame_done,
    output logic        sched_idle,
    output logic [15:0] issued_cnt,
    output logic        timeout_err
);

    // state       | meaning
    // S_IDLE      | waiting for a queued command and lcd_busy low
    // S_ISSUE     | lcd_cmd_valid strobe, count the issue
    // S_HOLD      | one cycle blind to lcd_busy while the controller raises it
    // S_WAIT_BUSY | wait for lcd_busy to fall
    // S_WAIT_DONE | write command in flight, wait for lcd_done
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lcd_cmd_sched: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lcd_cmd_sched: TIMEOUT must be at least 1");
    end

    logic [2:0]    mem_q   [2][DEPTH];
    logic [2:0]    mem_d   [2][DEPTH];
    logic [AW-1:0] wptr_q  [2];
    logic [AW-1:0] wptr_d  [2];
    logic [AW-1:0] rptr_q  [2];
    logic [AW-1:0] rptr_d  [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [2:0]    req_cmd [2];
    logic [2:0]    head    [2];
    logic [1:0]    req_valid;
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    push;
    logic [1:0]    pop;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  lcd_cmd_q, lcd_cmd_d;
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        gnt;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_cmd[0] = req0_cmd;
    assign req_cmd[1] = req1_cmd;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]  = (cnt_q[i] == CW'(DEPTH));
            empty[i] = (cnt_q[i] == '0);
            push[i]  = req_valid[i] && !full[i];
            head[i]  = mem_q[i][rptr_q[i]];
        end
    end

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = req_cmd[i];
                wptr_d[i] = wptr_q[i] + AW'(1);
            end
            if (pop[i]) begin
                rptr_d[i] = rptr_q[i] + AW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

`ifdef LCD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lcd_cmd_d    = lcd_cmd_q;
        issued_cnt_d = issued_cnt_q;
        frame_done_d = 1'b0;
        pop          = '0;
        gnt          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!lcd_busy && (empty != 2'b11)) begin
                    gnt          = (empty == 2'b00) ? ~last_grant_q : empty[0];
                    pop[gnt]     = 1'b1;
                    lcd_cmd_d    = head[gnt];
                    last_grant_d = gnt;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issued_cnt_d = issued_cnt_q + 16'd1;
                state_d      = (lcd_cmd_q == WRITE_CMD) ? S_WAIT_DONE : S_HOLD;
            end
            S_HOLD: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!lcd_busy) state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (lcd_done) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef LCD_SCHED_TIMEOUT_EN
        // A normal exit in the same cycle as the limit wins over the watchdog.
        tmo_err_d = tmo_err_q;
        if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) && state_d == state_q
                && tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            tmo_err_d = 1'b1;
            state_d   = S_IDLE;
        end
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            lcd_cmd_q    <= '0;
            issued_cnt_q <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lcd_cmd_q    <= lcd_cmd_d;
            issued_cnt_q <= issued_cnt_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef LCD_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req0_ready    = !full[0];
    assign req1_ready    = !full[1];
    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = (state_q == S_ISSUE);
    assign frame_done    = frame_done_q;
    assign issued_cnt    = issued_cnt_q;
    assign sched_idle    = (state_q == S_IDLE) && (empty == 2'b11);

endmodule

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
- Command scheduler in front of the LCD image controller's cmd/cmd_valid/busy/done port.
- Buffers commands from two requesters (req0 = host, req1 = script/replay engine), each in its own FIFO, and arbitrates between them round-robin.
- Issues one command at a time, only when the controller is not busy.
- Tracks the write/terminate command until the controller raises done, then reports frame completion.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of 2, minimum 2.
- WRITE_CMD, 3'd0, command code that triggers IRAM write-back and frame end.
- TIMEOUT, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 push strobe.
- req0_cmd  in  3  requester 0 command code.
- req0_ready  out  1  FIFO0 not full.
- req1_valid  in  1  requester 1 push strobe.
- req1_cmd  in  3  requester 1 command code.
- req1_ready  out  1  FIFO1 not full.
- lcd_cmd  out  3  command to LCD controller.
- lcd_cmd_valid  out  1  one-cycle issue strobe.
- lcd_busy  in  1  LCD controller busy.
- lcd_done  in  1  LCD controller frame done.
- frame_done  out  1  one-cycle pulse after lcd_done is observed in WAIT_DONE.
- sched_idle  out  1  state==IDLE and both FIFOs empty.
- issued_cnt  out  16  commands issued; wraps 0xFFFF->0.
- timeout_err  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset: both FIFOs emptied; state IDLE; last_grant=1.
- Reset output values: lcd_cmd=0, lcd_cmd_valid=0, frame_done=0, issued_cnt=0, timeout_err=0, req*_ready=1, sched_idle=1.
- Reset asserted mid-operation aborts everything on the next edge; queued commands are discarded.
- Push: accepted when reqN_valid && reqN_ready.
  - reqN_ready = !full, computed from the registered count only. A push on a full FIFO is dropped, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Arbitration (IDLE only, when lcd_busy==0):
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the one not equal to last_grant.
  - On grant: pop the head entry, register it into lcd_cmd, update last_grant.
- FSM:
  - IDLE -> ISSUE on grant.
  - ISSUE: lcd_cmd_valid=1 for exactly one cycle; issued_cnt++. If cmd==WRITE_CMD go to WAIT_DONE, else go to HOLD.
  - HOLD: one cycle; lcd_busy is ignored (covers the controller's busy-rise latency) -> WAIT_BUSY.
  - WAIT_BUSY: stay while lcd_busy==1; -> IDLE when lcd_busy==0.
  - WAIT_DONE: stay until lcd_done==1; then frame_done=1 for one cycle -> IDLE.
- Latency: with a non-empty FIFO and lcd_busy==0 in IDLE at edge t, lcd_cmd_valid is high in cycle t+1.
  - Minimum issue spacing is 4 cycles (IDLE, ISSUE, HOLD, WAIT_BUSY).
- lcd_cmd holds its last value between issues.
- lcd_done seen outside WAIT_DONE is ignored.
- Pushes continue to be accepted in every state.

Optional Feature:
- Macro: LCD_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT: set timeout_err (sticky until reset), force the FSM to IDLE, and do not emit frame_done.
  - The counter clears on every state entry.
- Undefined: no counter is built; timeout_err is tied to 0; the FSM waits indefinitely.

Test Plan:
- Reset, then push req0 cmds 1,2,3 with lcd_busy modeled 2 cycles after each strobe -> lcd_cmd sequence 1,2,3; strobes 4+ cycles apart; issued_cnt=3; sched_idle=1 at end.
- Both FIFOs preloaded (req0: 1,1; req1: 4,4) while lcd_busy=1, then release busy -> issue order 1,4,1,4 (req0 wins first after reset).
- Push 5 cmds into req0 with DEPTH=4 and lcd_busy held 1 -> req0_ready=0 after the 4th push; 5th dropped; only 4 issues after busy drops.
- Issue WRITE_CMD=0; hold lcd_done low 10 cycles, then pulse it -> no further lcd_cmd_valid while waiting, even with req1 non-empty; frame_done pulses 1 cycle; next queued cmd issues afterwards.
- Assert reset while in WAIT_BUSY with 2 cmds queued -> all outputs at reset values next cycle; no further issues after reset drops.
- With LCD_SCHED_TIMEOUT_EN and TIMEOUT=8, hold lcd_busy=1 after an issue -> timeout_err=1 eight cycles after entering WAIT_BUSY; FSM back in IDLE; flag stays 1 until reset.
